// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch front-panel controller:
// FSM state encoding and the BCD digit width.
package stopwatch_ctrl_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_t;

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button debouncer: 2-FF synchroniser, stability counter and press detect.
// press is high for the single cycle in which the accepted level rises,
// so the consumer can register its reaction on the same edge that
// updates the level. Releases are accepted silently.
module sw_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic clr,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             level;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Accept a new level only after it has differed from the current one
    // for DB_CYCLES consecutive cycles; any return to the old level restarts.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (s2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            level <= s2;
            cnt   <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign press = s2 & ~level & (cnt == CNT_MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch front-panel controller: three debounced buttons drive the
// IDLE/RUN/PAUSE/LAP machine, which issues one-cycle go/stop/clr pulses to
// the counter, captures the lap time and selects what the display shows.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int DB_CYCLES = 1000000,
    parameter int NDIG      = 6
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    btn_ss,
    input  logic                    btn_lap,
    input  logic                    btn_rst,
    input  logic [DIGIT_W*NDIG-1:0] time_in,
    output logic                    sw_go,
    output logic                    sw_stop,
    output logic                    sw_clr,
    output logic [DIGIT_W*NDIG-1:0] disp_time,
    output logic                    run,
    output logic                    lap_active
);

    sw_state_t               state;
    logic [DIGIT_W*NDIG-1:0] lap_reg;
    logic                    ss_ev;
    logic                    lap_ev;
    logic                    rst_ev;

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_ss),
        .press (ss_ev)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_lap),
        .press (lap_ev)
    );

    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_rst (
        .clk   (clk),
        .clr   (clr),
        .raw   (btn_rst),
        .press (rst_ev)
    );

    // Control FSM with registered pulses; clear beats start/stop beats lap,
    // and a losing event in the same cycle is simply dropped.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state      <= ST_IDLE;
            lap_reg    <= '0;
            sw_go      <= 1'b0;
            sw_stop    <= 1'b0;
            sw_clr     <= 1'b0;
            run        <= 1'b0;
            lap_active <= 1'b0;
        end else begin
            sw_go   <= 1'b0;
            sw_stop <= 1'b0;
            sw_clr  <= 1'b0;
            if (rst_ev) begin
                // The counter stops itself on clr, so no stop pulse is sent.
                state      <= ST_IDLE;
                sw_clr     <= 1'b1;
                lap_reg    <= '0;
                run        <= 1'b0;
                lap_active <= 1'b0;
            end else if (ss_ev) begin
                case (state)
                    ST_IDLE, ST_PAUSE: begin
                        state      <= ST_RUN;
                        sw_go      <= 1'b1;
                        run        <= 1'b1;
                        lap_active <= 1'b0;
                    end
                    default: begin
                        state      <= ST_PAUSE;
                        sw_stop    <= 1'b1;
                        run        <= 1'b0;
                        lap_active <= 1'b0;
                    end
                endcase
            end else if (lap_ev) begin
                case (state)
                    ST_RUN: begin
                        state      <= ST_LAP;
                        lap_reg    <= time_in;
                        lap_active <= 1'b1;
                    end
                    ST_LAP: begin
                        state      <= ST_RUN;
                        lap_active <= 1'b0;
                    end
                    default: begin
                        state <= state;
                    end
                endcase
            end
        end
    end

    assign disp_time = lap_active ? lap_reg : time_in;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DB_CYCLES=4, NDIG=6.
module tb_stopwatch_ctrl;

    localparam int DB_CYCLES = 4;
    localparam int NDIG      = 6;
    localparam int PULSE_AT  = DB_CYCLES + 2;

    logic          clk = 1'b0;
    logic          clr;
    logic          btn_ss;
    logic          btn_lap;
    logic          btn_rst;
    logic [23:0]   time_in;
    logic          sw_go;
    logic          sw_stop;
    logic          sw_clr;
    logic [23:0]   disp_time;
    logic          run;
    logic          lap_active;

    int checks   = 0;
    int failures = 0;

    stopwatch_ctrl #(.DB_CYCLES(DB_CYCLES), .NDIG(NDIG)) dut (
        .clk        (clk),
        .clr        (clr),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .btn_rst    (btn_rst),
        .time_in    (time_in),
        .sw_go      (sw_go),
        .sw_stop    (sw_stop),
        .sw_clr     (sw_clr),
        .disp_time  (disp_time),
        .run        (run),
        .lap_active (lap_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the masked buttons (bit0 ss, bit1 lap, bit2 rst) for 12 edges,
    // expecting the given pulses only on edge DB_CYCLES+2, then release and
    // expect silence.
    task automatic press(input logic [2:0] mask, input logic eg, input logic es, input logic ec);
        btn_ss  = mask[0];
        btn_lap = mask[1];
        btn_rst = mask[2];
        for (int i = 1; i <= 12; i++) begin
            tick();
            chk("sw_go_hold",   {31'd0, sw_go},   {31'd0, (i == PULSE_AT) & eg});
            chk("sw_stop_hold", {31'd0, sw_stop}, {31'd0, (i == PULSE_AT) & es});
            chk("sw_clr_hold",  {31'd0, sw_clr},  {31'd0, (i == PULSE_AT) & ec});
        end
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("pulses_release", {29'd0, sw_go, sw_stop, sw_clr}, 32'd0);
        end
    endtask

    initial begin
        clr     = 1'b0;
        btn_ss  = 1'b0;
        btn_lap = 1'b0;
        btn_rst = 1'b0;
        time_in = 24'h000042;
        #2;
        clr = 1'b1;
        #1;
        chk("rst_sw_go",      {31'd0, sw_go},      32'd0);
        chk("rst_sw_stop",    {31'd0, sw_stop},    32'd0);
        chk("rst_sw_clr",     {31'd0, sw_clr},     32'd0);
        chk("rst_run",        {31'd0, run},        32'd0);
        chk("rst_lap_active", {31'd0, lap_active}, 32'd0);
        chk("rst_disp",       {8'd0, disp_time},   32'h000042);
        tick();
        tick();
        clr = 1'b0;
        tick();

        // Short glitch on start/stop: filtered, stays idle.
        btn_ss = 1'b1;
        tick();
        tick();
        tick();
        btn_ss = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("glitch_pulses", {29'd0, sw_go, sw_stop, sw_clr}, 32'd0);
            chk("glitch_run",    {31'd0, run},                    32'd0);
        end

        // IDLE -> RUN.
        press(3'b001, 1'b1, 1'b0, 1'b0);
        chk("run_after_go", {31'd0, run}, 32'd1);

        // RUN -> PAUSE, lap ignored in PAUSE, PAUSE -> RUN.
        press(3'b001, 1'b0, 1'b1, 1'b0);
        chk("pause_run", {31'd0, run}, 32'd0);
        press(3'b010, 1'b0, 1'b0, 1'b0);
        chk("pause_lap_ignored", {31'd0, lap_active}, 32'd0);
        chk("pause_disp",        {8'd0, disp_time},   32'h000042);
        press(3'b001, 1'b1, 1'b0, 1'b0);
        chk("resume_run", {31'd0, run}, 32'd1);

        // Lap capture freezes the display, second lap returns to live time.
        time_in = 24'h012345;
        press(3'b010, 1'b0, 1'b0, 1'b0);
        chk("lap_active_on", {31'd0, lap_active}, 32'd1);
        chk("lap_run",       {31'd0, run},        32'd1);
        chk("lap_disp",      {8'd0, disp_time},   32'h012345);
        time_in = 24'h012350;
        tick();
        chk("lap_disp_frozen", {8'd0, disp_time}, 32'h012345);
        press(3'b010, 1'b0, 1'b0, 1'b0);
        chk("lap_active_off", {31'd0, lap_active}, 32'd0);
        chk("lap_disp_live",  {8'd0, disp_time},   32'h012350);
        chk("lap_back_run",   {31'd0, run},        32'd1);

        // Start/stop and clear accepted together: clear wins alone.
        press(3'b101, 1'b0, 1'b0, 1'b1);
        chk("prio_run",        {31'd0, run},        32'd0);
        chk("prio_lap_active", {31'd0, lap_active}, 32'd0);

        // Async reset while in LAP.
        press(3'b001, 1'b1, 1'b0, 1'b0);
        press(3'b010, 1'b0, 1'b0, 1'b0);
        chk("lap2_active", {31'd0, lap_active}, 32'd1);
        #3;
        clr = 1'b1;
        #1;
        chk("lapclr_run",        {31'd0, run},        32'd0);
        chk("lapclr_lap_active", {31'd0, lap_active}, 32'd0);
        chk("lapclr_disp",       {8'd0, disp_time},   32'h012350);
        tick();
        clr = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("lapclr_pulses", {29'd0, sw_go, sw_stop, sw_clr}, 32'd0);
        end

        // Async reset mid-run shows live time immediately.
        press(3'b001, 1'b1, 1'b0, 1'b0);
        time_in = 24'h000042;
        chk("midrun_run_before", {31'd0, run}, 32'd1);
        #3;
        clr = 1'b1;
        #1;
        chk("midrun_pulses", {29'd0, sw_go, sw_stop, sw_clr}, 32'd0);
        chk("midrun_run",    {31'd0, run},        32'd0);
        chk("midrun_lap",    {31'd0, lap_active}, 32'd0);
        chk("midrun_disp",   {8'd0, disp_time},   32'h000042);
        tick();
        clr = 1'b0;
        tick();

        // Clear from IDLE still pulses sw_clr; lap from IDLE is ignored.
        press(3'b100, 1'b0, 1'b0, 1'b1);
        chk("idle_clr_run", {31'd0, run}, 32'd0);
        press(3'b010, 1'b0, 1'b0, 1'b0);
        chk("idle_lap_ignored", {31'd0, lap_active}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
